nco_sweep_ctrl: RTL

//  Upstream controller for the NCO. Generates stepped frequency sweeps (chirps) on the NCO frequency/phase

---
 rtl/nco_pkg.sv | 13 +
 rtl/nco_step_sat.sv | 33 +++
 rtl/nco_sweep_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - shared widths and FSM state type for the NCO sweep controller
package nco_pkg;
    localparam int FRE_W   = 24;
    localparam int PHA_W   = 7;
    localparam int DWELL_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        DWELL  = 2'd2,
        FINISH = 2'd3
    } state_t;
endpackage

// File: rtl/nco_step_sat.sv
// rtl/nco_step_sat.sv - combinational saturating up/down frequency step
module nco_step_sat
    import nco_pkg::*;
#(
    parameter int W = FRE_W
) (
    input  logic [W-1:0] i_cur,
    input  logic [W-1:0] i_step,
    input  logic [W-1:0] i_stop,
    input  logic         i_dir_up,
    output logic [W-1:0] o_next,
    output logic         o_hit
);
    logic [W:0]   w_sum;
    logic [W:0]   w_diff;
    logic [W-1:0] w_next;

    // One extra bit catches carry/borrow so the ramp clamps at the endpoint instead of wrapping.
    always_comb begin
        w_sum  = {1'b0, i_cur} + {1'b0, i_step};
        w_diff = {1'b0, i_cur} - {1'b0, i_step};
        if (i_step == '0) begin
            w_next = i_stop;
        end else if (i_dir_up) begin
            w_next = (w_sum[W] || (w_sum[W-1:0] >= i_stop)) ? i_stop : w_sum[W-1:0];
        end else begin
            w_next = (w_diff[W] || (w_diff[W-1:0] <= i_stop)) ? i_stop : w_diff[W-1:0];
        end
    end

    assign o_next = w_next;
    assign o_hit  = (w_next == i_stop);
endmodule

// File: rtl/nco_sweep_ctrl.sv
// rtl/nco_sweep_ctrl.sv - stepped frequency sweep sequencer driving NCO frequency/phase/enable
module nco_sweep_ctrl
    import nco_pkg::*;
#(
    parameter int FRE_WIDTH   = FRE_W,
    parameter int PHA_WIDTH   = PHA_W,
    parameter int DWELL_WIDTH = DWELL_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   cont,
    input  logic [FRE_WIDTH-1:0]   f_start,
    input  logic [FRE_WIDTH-1:0]   f_stop,
    input  logic [FRE_WIDTH-1:0]   f_step,
    input  logic [DWELL_WIDTH-1:0] dwell,
    input  logic [PHA_WIDTH-1:0]   pha_cfg,
    output logic [FRE_WIDTH-1:0]   fre_chtr,
    output logic [PHA_WIDTH-1:0]   pha_chtr,
    output logic                   nco_en,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted
);
    state_t                 r_state, w_state_nxt;
    logic [FRE_WIDTH-1:0]   r_fre, w_fre_nxt;
    logic [PHA_WIDTH-1:0]   r_pha, w_pha_nxt;
    logic                   r_en, w_en_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_done, w_done_nxt;
    logic                   r_aborted, w_aborted_nxt;
    logic [DWELL_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [FRE_WIDTH-1:0]   r_f_start, w_f_start_nxt;
    logic [FRE_WIDTH-1:0]   r_f_stop, w_f_stop_nxt;
    logic [FRE_WIDTH-1:0]   r_f_step, w_f_step_nxt;
    logic [DWELL_WIDTH-1:0] r_dwell_m1, w_dwell_m1_nxt;
    logic                   r_cont, w_cont_nxt;
    logic                   r_dir_up, w_dir_up_nxt;
    logic                   r_at_stop, w_at_stop_nxt;
    logic [FRE_WIDTH-1:0]   w_next;
    logic                   w_hit;

    nco_step_sat #(.W(FRE_WIDTH)) u_step (
        .i_cur    (r_fre),
        .i_step   (r_f_step),
        .i_stop   (r_f_stop),
        .i_dir_up (r_dir_up),
        .o_next   (w_next),
        .o_hit    (w_hit)
    );

    // r_at_stop tracks whether the value on fre_chtr is already the endpoint.
    always_comb begin
        w_state_nxt    = r_state;
        w_fre_nxt      = r_fre;
        w_pha_nxt      = r_pha;
        w_en_nxt       = r_en;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_aborted_nxt  = 1'b0;
        w_cnt_nxt      = r_cnt;
        w_f_start_nxt  = r_f_start;
        w_f_stop_nxt   = r_f_stop;
        w_f_step_nxt   = r_f_step;
        w_dwell_m1_nxt = r_dwell_m1;
        w_cont_nxt     = r_cont;
        w_dir_up_nxt   = r_dir_up;
        w_at_stop_nxt  = r_at_stop;
        case (r_state)
            IDLE: begin
                w_en_nxt   = 1'b0;
                w_busy_nxt = 1'b0;
                if (start && !stop) begin
                    w_f_start_nxt  = f_start;
                    w_f_stop_nxt   = f_stop;
                    w_f_step_nxt   = f_step;
                    w_dwell_m1_nxt = (dwell == '0) ? '0 : dwell - 1'b1;
                    w_cont_nxt     = cont;
                    w_dir_up_nxt   = (f_stop >= f_start);
                    w_at_stop_nxt  = (f_start == f_stop);
                    w_fre_nxt      = f_start;
                    w_pha_nxt      = pha_cfg;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = SETUP;
                end
            end
            SETUP: begin
                if (stop) begin
                    w_state_nxt   = FINISH;
                    w_done_nxt    = 1'b1;
                    w_aborted_nxt = 1'b1;
                    w_en_nxt      = 1'b0;
                end else begin
                    w_state_nxt = DWELL;
                    w_en_nxt    = 1'b1;
                    w_cnt_nxt   = r_dwell_m1;
                end
            end
            DWELL: begin
                if (stop) begin
                    w_state_nxt   = FINISH;
                    w_done_nxt    = 1'b1;
                    w_aborted_nxt = 1'b1;
                    w_en_nxt      = 1'b0;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (r_at_stop) begin
                    if (r_cont) begin
                        w_fre_nxt     = r_f_start;
                        w_at_stop_nxt = (r_f_start == r_f_stop);
                        w_cnt_nxt     = r_dwell_m1;
                    end else begin
                        w_state_nxt = FINISH;
                        w_done_nxt  = 1'b1;
                        w_en_nxt    = 1'b0;
                    end
                end else begin
                    w_fre_nxt     = w_next;
                    w_at_stop_nxt = w_hit;
                    w_cnt_nxt     = r_dwell_m1;
                end
            end
            FINISH: begin
                w_state_nxt = IDLE;
                w_en_nxt    = 1'b0;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_en_nxt    = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_fre      <= '0;
            r_pha      <= '0;
            r_en       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_cnt      <= '0;
            r_f_start  <= '0;
            r_f_stop   <= '0;
            r_f_step   <= '0;
            r_dwell_m1 <= '0;
            r_cont     <= 1'b0;
            r_dir_up   <= 1'b0;
            r_at_stop  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fre      <= w_fre_nxt;
            r_pha      <= w_pha_nxt;
            r_en       <= w_en_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_aborted  <= w_aborted_nxt;
            r_cnt      <= w_cnt_nxt;
            r_f_start  <= w_f_start_nxt;
            r_f_stop   <= w_f_stop_nxt;
            r_f_step   <= w_f_step_nxt;
            r_dwell_m1 <= w_dwell_m1_nxt;
            r_cont     <= w_cont_nxt;
            r_dir_up   <= w_dir_up_nxt;
            r_at_stop  <= w_at_stop_nxt;
        end
    end

    assign fre_chtr = r_fre;
    assign pha_chtr = r_pha;
    assign nco_en   = r_en;
    assign busy     = r_busy;
    assign done     = r_done;
    assign aborted  = r_aborted;
endmodule
